// File: rtl/serial_subtractor_12bits.sv
// rtl/serial_subtractor_12bits.sv - bit-serial A - B - Bin subtractor, LSB first, one bit per clock
module serial_subtractor_12bits #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bo,
    output logic             V
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] dsh_q, dsh_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             borrow_q, borrow_d;
    logic             bo_q, bo_d;
    logic             v_q, v_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             a_bit, b_bit, d_bit, borrow_nxt;
    logic [WIDTH-1:0] d_full;

    // Operands stay put; the counter selects the bit, so the MSBs remain available for V.
    always_comb begin
        a_bit      = a_q[cnt_q];
        b_bit      = b_q[cnt_q];
        d_bit      = a_bit ^ b_bit ^ borrow_q;
        borrow_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);
        d_full     = {d_bit, dsh_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        dsh_d    = dsh_q;
        d_d      = d_q;
        borrow_d = borrow_q;
        bo_d     = bo_q;
        v_d      = v_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = Bin;
                    cnt_d    = '0;
                    dsh_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                dsh_d    = d_full;
                borrow_d = borrow_nxt;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    d_d     = d_full;
                    bo_d    = borrow_nxt;
                    v_d     = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_bit != a_q[WIDTH-1]);
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            dsh_q    <= '0;
            d_q      <= '0;
            borrow_q <= 1'b0;
            bo_q     <= 1'b0;
            v_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            dsh_q    <= dsh_d;
            d_q      <= d_d;
            borrow_q <= borrow_d;
            bo_q     <= bo_d;
            v_q      <= v_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = d_q;
    assign Bo   = bo_q;
    assign V    = v_q;

endmodule

// File: tb/tb_serial_subtractor_12bits.sv
// tb/tb_serial_subtractor_12bits.sv - self-checking bench for serial_subtractor_12bits
module tb_serial_subtractor_12bits;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         Bo;
    logic         V;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bo;
        logic         v;
    } vec_t;

    vec_t vecs[6];

    serial_subtractor_12bits #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a),
        .B     (b),
        .Bin   (bin),
        .busy  (busy),
        .done  (done),
        .D     (D),
        .Bo    (Bo),
        .V     (V)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain wide unsigned arithmetic for {Bo,D}; V from the sign rule on latched operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                         output logic [W-1:0] md, output logic mbo, output logic mv);
        logic [W:0] full;
        full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        md   = full[W-1:0];
        mbo  = full[W];
        mv   = (ma[W-1] != mb[W-1]) && (md[W-1] != ma[W-1]);
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
        a     = ia;
        b     = ib;
        bin   = ibin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bcnt, output logic stable);
        logic [W-1:0] hd;
        logic         hbo, hv;
        hd     = D;
        hbo    = Bo;
        hv     = V;
        lat    = 0;
        bcnt   = 0;
        stable = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) bcnt++;
            if (D !== hd || Bo !== hbo || V !== hv) stable = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_res(input string tag, input logic [W-1:0] ed, input logic ebo, input logic ev);
        chk({tag, "_D"}, D, ed);
        chk({tag, "_Bo"}, Bo, ebo);
        chk({tag, "_V"}, V, ev);
    endtask

    task automatic count_done(input int n, output int pulses, output int busys);
        pulses = 0;
        busys  = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
            if (busy === 1'b1) busys++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat, bcnt, pulses, busys, gap;
        logic         stable;
        logic [W-1:0] ra, rb, ed;
        logic         rbin, ebo, ev;

        vecs[0] = '{12'hc23, 12'h0b4, 1'b0, 12'hb6f, 1'b0, 1'b0};
        vecs[1] = '{12'h000, 12'hfff, 1'b1, 12'h000, 1'b1, 1'b0};
        vecs[2] = '{12'h800, 12'h001, 1'b0, 12'h7ff, 1'b0, 1'b1};
        vecs[3] = '{12'h123, 12'h001, 1'b0, 12'h122, 1'b0, 1'b0};
        vecs[4] = '{12'h7ff, 12'hfff, 1'b0, 12'h800, 1'b1, 1'b1};
        vecs[5] = '{12'hfff, 12'hfff, 1'b1, 12'hfff, 1'b1, 1'b0};

        // Reset overrides a held start.
        rst   = 1'b1;
        start = 1'b1;
        a     = 12'hc23;
        b     = 12'h0b4;
        bin   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        check_res("rst", 12'h000, 1'b0, 1'b0);

        // First edge with rst=0 and start=1 is accepted.
        rst = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt, stable);
        chk("first_lat", lat, 12);
        chk("first_busy_cycles", bcnt, 12);
        check_res("first", 12'hb6f, 1'b0, 1'b0);
        @(negedge clk);
        chk("first_done_width", done, 1'b0);

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].bin);
            wait_done(lat, bcnt, stable);
            chk($sformatf("vec%0d_lat", i), lat, 12);
            chk($sformatf("vec%0d_busy_cycles", i), bcnt, 12);
            chk($sformatf("vec%0d_hold", i), stable, 1'b1);
            check_res($sformatf("vec%0d", i), vecs[i].d, vecs[i].bo, vecs[i].v);
            chk($sformatf("vec%0d_busy_at_done", i), busy, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d_done_width", i), done, 1'b0);
        end

        // Back-to-back: second request issued in the DONE cycle.
        issue(12'hc23, 12'h0b4, 1'b1);
        wait_done(lat, bcnt, stable);
        check_res("b2b_first", 12'hb6e, 1'b0, 1'b0);
        issue(12'h023, 12'h0b4, 1'b1);
        wait_done(lat, bcnt, stable);
        chk("b2b_spacing", lat + 1, 13);
        chk("b2b_hold", stable, 1'b1);
        check_res("b2b_second", 12'hf6e, 1'b1, 1'b0);
        @(negedge clk);

        // Start during SHIFT is ignored.
        issue(12'h123, 12'h001, 1'b0);
        repeat (4) @(negedge clk);
        a     = 12'h000;
        b     = 12'h001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bcnt, stable);
        chk("ign_lat", lat, 7);
        check_res("ign", 12'h122, 1'b0, 1'b0);
        count_done(20, pulses, busys);
        chk("ign_extra_done", pulses, 0);
        chk("ign_extra_busy", busys, 0);

        // Reset mid-operation aborts it.
        issue(12'hfff, 12'h001, 1'b0);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        check_res("abort", 12'h000, 1'b0, 1'b0);
        count_done(20, pulses, busys);
        chk("abort_no_done", pulses, 0);
        issue(12'h800, 12'h001, 1'b0);
        wait_done(lat, bcnt, stable);
        chk("after_abort_lat", lat, 12);
        check_res("after_abort", 12'h7ff, 1'b0, 1'b1);

        // Random scoreboard with 0..3 idle cycles between requests.
        for (int i = 0; i < 1000; i++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            ra   = W'($urandom);
            rb   = W'($urandom);
            rbin = 1'($urandom);
            model(ra, rb, rbin, ed, ebo, ev);
            issue(ra, rb, rbin);
            wait_done(lat, bcnt, stable);
            chk($sformatf("rnd%0d_lat", i), lat, 12);
            check_res($sformatf("rnd%0d", i), ed, ebo, ev);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
